rule_scheduler: RTL and testbench

Round-robin scheduler that drives the one-hot rule-enable vector of a translated guarded-command system (e.g. the mutual-exclusion model's `io_en_a`). Each cycle it fires at most one enabled rule, rotating priority for fairness. It runs for a programmed budget of firings and flags completion, or flags deadlock when no rule is enabled. It sits between the run-control logic and the `system` datapath, replacing free nondeterministic `io_en_a` with a fair, bounded schedule.

---
 rtl/rule_scheduler.sv | 132 +++++++++++++
 tb/tb_rule_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rule_scheduler.sv
// rule_scheduler
//   Fair, bounded round-robin scheduler for the rule-enable vector of a
//   guarded-command system. Fires at most one enabled rule per cycle,
//   rotating priority past the last granted rule. A run is started with a
//   firing budget and ends in DONE when the budget is spent, or in STALL
//   when no rule is enabled.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   io_start     in   pulse: latch io_budget and begin a run
//   io_budget    in   number of firings for the run
//   io_pause     in   hold everything while in RUN
//   io_guard     in   per-rule enable conditions from the system
//   io_en_a      out  one-hot rule fire (or zero), combinational in RUN
//   io_busy      out  state == RUN
//   io_done      out  state == DONE
//   io_deadlock  out  state == STALL
//   io_fired     out  firings in the current or last run
module rule_scheduler #(
    parameter int NUM_RULES = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic [CNT_W-1:0]     io_budget,
    input  logic                 io_pause,
    input  logic [NUM_RULES-1:0] io_guard,
    output logic [NUM_RULES-1:0] io_en_a,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_deadlock,
    output logic [CNT_W-1:0]     io_fired
);

    localparam int PTR_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_STALL
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   r_fired;
    logic [CNT_W-1:0]   w_fired_nxt;
    logic [CNT_W-1:0]   r_budget;
    logic [CNT_W-1:0]   w_budget_nxt;
    logic [CNT_W-1:0]   w_fired_inc;
    logic [PTR_W-1:0]   w_grant;
    logic               w_found;
    logic [PTR_W-1:0]   w_grant_inc;

    // Rotating priority search: examine rules ptr, ptr+1, ... wrapping,
    // and keep the first enabled one.
    always_comb begin
        int unsigned idx;
        w_grant = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_RULES; i++) begin
            idx = int'(r_ptr) + i;
            if (idx >= NUM_RULES) begin
                idx = idx - NUM_RULES;
            end
            if (!w_found && io_guard[idx]) begin
                w_found = 1'b1;
                w_grant = PTR_W'(idx);
            end
        end
    end

    assign w_grant_inc = (w_grant == PTR_W'(NUM_RULES - 1)) ? '0 : w_grant + 1'b1;
    assign w_fired_inc = r_fired + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_fired_nxt  = r_fired;
        w_budget_nxt = r_budget;
        io_en_a      = '0;
        case (r_state)
            S_RUN: begin
                if (!io_pause) begin
                    if (w_found) begin
                        io_en_a     = NUM_RULES'(1) << w_grant;
                        w_ptr_nxt   = w_grant_inc;
                        w_fired_nxt = w_fired_inc;
                        if (w_fired_inc == r_budget) begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_state_nxt = S_STALL;
                    end
                end
            end
            default: begin
                // IDLE, DONE and STALL all restart identically.
                if (io_start) begin
                    w_budget_nxt = io_budget;
                    w_fired_nxt  = '0;
                    w_ptr_nxt    = '0;
                    w_state_nxt  = (io_budget == '0) ? S_DONE : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_fired  <= '0;
            r_budget <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_fired  <= w_fired_nxt;
            r_budget <= w_budget_nxt;
        end
    end

    assign io_busy     = (r_state == S_RUN);
    assign io_done     = (r_state == S_DONE);
    assign io_deadlock = (r_state == S_STALL);
    assign io_fired    = r_fired;

endmodule

// File: tb/tb_rule_scheduler.sv
module tb_rule_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_start;
    logic [15:0] io_budget;
    logic        io_pause;
    logic [3:0]  io_guard;
    logic [3:0]  io_en_a;
    logic        io_busy;
    logic        io_done;
    logic        io_deadlock;
    logic [15:0] io_fired;

    logic [3:0]  tb_guard;
    logic        use_sys;
    logic [1:0]  n0, n1;
    logic        x;
    logic [3:0]  sys_guard;

    int n_checks = 0;
    int n_errors = 0;
    int crit_viol = 0;
    int multi_hot = 0;

    always #5 clock = ~clock;

    rule_scheduler #(.NUM_RULES(4), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_start   (io_start),
        .io_budget  (io_budget),
        .io_pause   (io_pause),
        .io_guard   (io_guard),
        .io_en_a    (io_en_a),
        .io_busy    (io_busy),
        .io_done    (io_done),
        .io_deadlock(io_deadlock),
        .io_fired   (io_fired)
    );

    // Two-process mutex: n = 0 noncrit, 1 waiting, 2 crit; x = semaphore.
    // Rule 2p: advance process p (0->1, or 1->2 taking x). Rule 2p+1: leave crit.
    assign sys_guard = {n1 == 2'd2, (n1 == 2'd0) || (n1 == 2'd1 && x),
                        n0 == 2'd2, (n0 == 2'd0) || (n0 == 2'd1 && x)};
    assign io_guard  = use_sys ? sys_guard : tb_guard;

    always @(posedge clock) begin
        if (!use_sys) begin
            n0 <= 2'd0; n1 <= 2'd0; x <= 1'b1;
        end else begin
            if (io_en_a[0]) begin
                if (n0 == 2'd0) n0 <= 2'd1;
                else begin n0 <= 2'd2; x <= 1'b0; end
            end
            if (io_en_a[1]) begin n0 <= 2'd0; x <= 1'b1; end
            if (io_en_a[2]) begin
                if (n1 == 2'd0) n1 <= 2'd1;
                else begin n1 <= 2'd2; x <= 1'b0; end
            end
            if (io_en_a[3]) begin n1 <= 2'd0; x <= 1'b1; end
        end
    end

    always @(negedge clock) begin
        if (use_sys && n0 == 2'd2 && n1 == 2'd2) crit_viol++;
        if (!$onehot0(io_en_a)) multi_hot++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [15:0] budget, input logic [3:0] guard);
        @(negedge clock);
        io_start  = 1'b1;
        io_budget = budget;
        tb_guard  = guard;
        @(negedge clock);
        io_start  = 1'b0;
        #1;
    endtask

    logic [3:0] exp_seq1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_seq2 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [3:0] exp_seq3 [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        reset = 1'b1; io_start = 1'b0; io_budget = '0; io_pause = 1'b0;
        tb_guard = 4'b1111; use_sys = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_en", io_en_a, 4'b0000);
        check("rst_busy", io_busy, 1'b0);
        check("rst_done", io_done, 1'b0);
        check("rst_dl", io_deadlock, 1'b0);
        check("rst_fired", io_fired, 16'd0);

        // Full rotation with all rules enabled.
        start_run(16'd5, 4'b1111);
        check("r1_busy", io_busy, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("r1_en%0d", i), io_en_a, exp_seq1[i]);
            @(negedge clock); #1;
        end
        check("r1_done", io_done, 1'b1);
        check("r1_busy_off", io_busy, 1'b0);
        check("r1_fired", io_fired, 16'd5);
        check("r1_en_done", io_en_a, 4'b0000);

        // Wrap and skip of disabled rules.
        start_run(16'd4, 4'b0101);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("r2_en%0d", i), io_en_a, exp_seq2[i]);
            @(negedge clock); #1;
        end
        check("r2_done", io_done, 1'b1);
        check("r2_fired", io_fired, 16'd4);

        // No rule enabled right after start.
        start_run(16'd3, 4'b0000);
        check("st_en", io_en_a, 4'b0000);
        check("st_busy", io_busy, 1'b1);
        @(negedge clock); #1;
        check("st_dl", io_deadlock, 1'b1);
        check("st_busy_off", io_busy, 1'b0);
        check("st_done", io_done, 1'b0);
        check("st_fired", io_fired, 16'd0);

        // Pause mid-run, even with guard forced to zero during the pause.
        start_run(16'd6, 4'b1111);
        check("p_en0", io_en_a, 4'b0001);
        @(negedge clock); #1;
        check("p_en1", io_en_a, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            io_pause = 1'b1;
            tb_guard = (i == 1) ? 4'b0000 : 4'b1111;
            #1;
            check($sformatf("p_hold_en%0d", i), io_en_a, 4'b0000);
            check($sformatf("p_hold_busy%0d", i), io_busy, 1'b1);
        end
        @(negedge clock);
        io_pause = 1'b0;
        tb_guard = 4'b1111;
        #1;
        check("p_fired_held", io_fired, 16'd2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("p_en_res%0d", i), io_en_a, exp_seq3[i]);
            @(negedge clock); #1;
        end
        check("p_done", io_done, 1'b1);
        check("p_fired", io_fired, 16'd6);

        // Zero budget finishes without firing.
        start_run(16'd0, 4'b1111);
        check("z_done", io_done, 1'b1);
        check("z_en", io_en_a, 4'b0000);
        check("z_fired", io_fired, 16'd0);

        // Asynchronous reset mid-run.
        start_run(16'd10, 4'b1111);
        @(negedge clock); #1;
        check("ar_fired_pre", io_fired, 16'd1);
        reset = 1'b1;
        #1;
        check("ar_en", io_en_a, 4'b0000);
        check("ar_busy", io_busy, 1'b0);
        check("ar_fired", io_fired, 16'd0);
        // Start held during reset must be ignored.
        io_start = 1'b1; io_budget = 16'd3;
        @(negedge clock);
        io_start = 1'b0;
        reset = 1'b0;
        #1;
        check("ar_idle_busy", io_busy, 1'b0);
        check("ar_idle_done", io_done, 1'b0);
        check("ar_idle_en", io_en_a, 4'b0000);

        // Closed loop with the mutex system.
        @(negedge clock);
        use_sys = 1'b1;
        start_run(16'd200, 4'b0000);
        for (int k = 0; k < 400 && !(io_done || io_deadlock); k++) begin
            @(negedge clock); #1;
        end
        check("mx_done", io_done, 1'b1);
        check("mx_dl", io_deadlock, 1'b0);
        check("mx_fired", io_fired, 16'd200);
        check("mx_crit", crit_viol, 0);
        check("onehot0", multi_hot, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
